// File: rtl/vram_scan_arbiter_if.sv
// Bus bundle between the video-memory arbiter and its CPU, RAM and display neighbours.
// The master modport is the environment side and the slave modport is the arbiter side.
interface vram_scan_arbiter_if #(
   parameter int unsigned ADDR_W = 17
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              cpu_ack;
   logic [7:0]        cpu_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              pix_ready;
   logic              pix_valid;
   logic [7:0]        pix_data;
   logic              frame_start;
   logic              underflow;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, pix_ready, frame_start,
      input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata, pix_valid, pix_data, underflow
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, pix_ready, frame_start,
      output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata, pix_valid, pix_data, underflow
   );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Shares one synchronous video-RAM port between CPU accesses and a raster-order
// scan-out prefetcher that feeds a small show-ahead pixel FIFO.
module vram_scan_arbiter #(
   parameter int unsigned H_RES      = 320,
   parameter int unsigned V_RES      = 240,
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                clk,
   input logic                reset,
   vram_scan_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned LVL_W = CNT_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

   localparam logic [1:0] GNT_IDLE  = 2'd0;
   localparam logic [1:0] GNT_FETCH = 2'd1;
   localparam logic [1:0] GNT_CPU   = 2'd2;

   logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              inflight_q, inflight_d;
   logic              cpu_busy_q, cpu_busy_d;
   logic              cpu_rd_q, cpu_rd_d;
   logic [7:0]        cpu_rdata_q, cpu_rdata_d;
   logic              underflow_q, underflow_d;
   logic [7:0]        fifo_q [FIFO_DEPTH];

   logic [LVL_W-1:0]  level;
   logic              room_ok;
   logic              urgent;
   logic [1:0]        gnt;
   logic              pix_valid;
   logic              push;
   logic              pop;

   // Occupied plus in-flight entries form the fetch credit.
   assign level   = {1'b0, count_q} + LVL_W'(inflight_q);
   assign room_ok = level < LVL_W'(FIFO_DEPTH);
   assign urgent  = level <= LVL_W'(1);

   always_comb begin
      gnt = GNT_IDLE;
      if (!bus.frame_start && room_ok && urgent) begin
         gnt = GNT_FETCH;
      end else if (bus.cpu_req && !cpu_busy_q) begin
         gnt = GNT_CPU;
      end else if (!bus.frame_start && room_ok) begin
         gnt = GNT_FETCH;
      end
   end

   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      unique case (gnt)
         GNT_FETCH: bus.mem_addr = scan_ptr_q;
         GNT_CPU: begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_we    = bus.cpu_we;
            bus.mem_wdata = bus.cpu_wdata;
         end
         default: ;
      endcase
   end

   assign pix_valid = count_q != '0;
   // A fetch returning in the frame_start cycle belongs to the old frame.
   assign push      = inflight_q && !bus.frame_start;
   assign pop       = bus.pix_ready && pix_valid;

   always_comb begin
      scan_ptr_d = scan_ptr_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (bus.frame_start) begin
         scan_ptr_d = '0;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (gnt == GNT_FETCH) begin
            scan_ptr_d = (scan_ptr_q == LAST_ADDR) ? '0 : scan_ptr_q + 1'b1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
         endcase
      end
   end

   // cpu_busy doubles as the ack strobe: set by the grant, cleared after the ack cycle.
   always_comb begin
      inflight_d  = gnt == GNT_FETCH;
      cpu_busy_d  = gnt == GNT_CPU;
      cpu_rd_d    = (gnt == GNT_CPU) && !bus.cpu_we;
      cpu_rdata_d = (cpu_busy_q && cpu_rd_q) ? bus.mem_rdata : cpu_rdata_q;
      underflow_d = underflow_q || (bus.pix_ready && !pix_valid);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_ptr_q  <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         inflight_q  <= 1'b0;
         cpu_busy_q  <= 1'b0;
         cpu_rd_q    <= 1'b0;
         cpu_rdata_q <= '0;
         underflow_q <= 1'b0;
      end else begin
         scan_ptr_q  <= scan_ptr_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         inflight_q  <= inflight_d;
         cpu_busy_q  <= cpu_busy_d;
         cpu_rd_q    <= cpu_rd_d;
         cpu_rdata_q <= cpu_rdata_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= bus.mem_rdata;
      end
   end

   assign bus.cpu_ack   = cpu_busy_q;
   assign bus.cpu_rdata = cpu_rdata_d;
   assign bus.pix_valid = pix_valid;
   assign bus.pix_data  = pix_valid ? fifo_q[rd_ptr_q] : 8'h00;
   assign bus.underflow = underflow_q;

endmodule
